// File: rtl/te_branch_map_decoder_if.sv
// Handshake bundle for te_branch_map_decoder: map/count input side, lane output side, flush.
// The master modport drives the pair, flush and out_ready; the slave modport is the decoder.
interface te_branch_map_decoder_if #(
   parameter int unsigned N                = 1,
   parameter int unsigned BRANCH_MAP_LEN   = 31,
   parameter int unsigned BRANCH_COUNT_LEN = 5
);
   logic                        in_valid;
   logic                        in_ready;
   logic [BRANCH_MAP_LEN-1:0]   map;
   logic [BRANCH_COUNT_LEN-1:0] branches;
   logic                        flush;
   logic [N-1:0]                out_valid;
   logic [N-1:0]                out_taken;
   logic                        out_last;
   logic                        out_ready;
   logic [BRANCH_COUNT_LEN-1:0] branches_left;
   logic                        busy;

   modport master (
      output in_valid, map, branches, flush, out_ready,
      input  in_ready, out_valid, out_taken, out_last, branches_left, busy
   );

   modport slave (
      input  in_valid, map, branches, flush, out_ready,
      output in_ready, out_valid, out_taken, out_last, branches_left, busy
   );
endinterface

// File: rtl/te_branch_map_decoder.sv
// Replays a branch map oldest-first (bit 0 first), up to N outcomes per beat.
// Optional macro TE_BRANCH_MAP_ZERO_IS_FULL_EN: a zero branch count means a full map.
module te_branch_map_decoder #(
   parameter int unsigned N                = 1,
   parameter int unsigned BRANCH_MAP_LEN   = 31,
   parameter int unsigned BRANCH_COUNT_LEN = 5
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   te_branch_map_decoder_if.slave bus
);

   localparam int unsigned IdxW = $clog2(BRANCH_MAP_LEN) + 1;
   localparam int unsigned CntW = BRANCH_COUNT_LEN;

   typedef enum logic [0:0] {StIdle, StDrain} state_e;

   state_e                    state_q, state_d;
   logic [BRANCH_MAP_LEN-1:0] map_q, map_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [CntW-1:0]           rem_q, rem_d;

   logic [CntW-1:0]           eff_cnt;
   logic [CntW-1:0]           beat_cnt;
   logic [BRANCH_MAP_LEN-1:0] map_sh;
   logic                      accept;

   // Counts above the map width are clamped to a full map.
   always_comb begin
      eff_cnt = bus.branches;
      if (32'(bus.branches) > BRANCH_MAP_LEN) begin
         eff_cnt = CntW'(BRANCH_MAP_LEN);
      end
`ifdef TE_BRANCH_MAP_ZERO_IS_FULL_EN
      if (bus.branches == '0) begin
         eff_cnt = CntW'(BRANCH_MAP_LEN);
      end
`endif
   end

   always_comb begin
      beat_cnt = CntW'(N);
      if (32'(rem_q) < N) begin
         beat_cnt = rem_q;
      end
   end

   assign bus.in_ready = (state_q == StIdle) & ~bus.flush;
   assign accept       = bus.in_valid & bus.in_ready;

   // Flush wins over both accept and beat transfer.
   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      if (bus.flush) begin
         state_d = StIdle;
         idx_d   = '0;
         rem_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept && (eff_cnt != '0)) begin
                  map_d   = bus.map;
                  idx_d   = '0;
                  rem_d   = eff_cnt;
                  state_d = StDrain;
               end
            end
            StDrain: begin
               if (bus.out_ready) begin
                  idx_d = idx_q + IdxW'(beat_cnt);
                  rem_d = rem_q - beat_cnt;
                  if (rem_q == beat_cnt) begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         map_q   <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
      end
   end

   assign map_sh = map_q >> idx_q;

   for (genvar g = 0; g < N; g++) begin : g_lane
      logic in_map;
      assign in_map = (int'(idx_q) + g) < int'(BRANCH_MAP_LEN);
      assign bus.out_valid[g] = (state_q == StDrain) && (int'(beat_cnt) > g) && in_map;
      if (g < BRANCH_MAP_LEN) begin : g_bit
         assign bus.out_taken[g] = bus.out_valid[g] & ~map_sh[g];
      end else begin : g_none
         assign bus.out_taken[g] = 1'b0;
      end
   end

   assign bus.out_last      = (state_q == StDrain) && (int'(rem_q) <= int'(N));
   assign bus.branches_left = rem_q;
   assign bus.busy          = (state_q == StDrain);

endmodule

// File: tb/tb_te_branch_map_decoder.sv
// Bench for te_branch_map_decoder: an N=1 and an N=4 instance checked against a beat scoreboard.
module tb_te_branch_map_decoder;

   typedef struct packed {
      logic [3:0] v;
      logic [3:0] t;
      logic       last;
      logic [4:0] left;
   } beat_t;

   logic        clk;
   logic        rst_n;
   int          sel;
   logic        in_valid;
   logic [30:0] map;
   logic [4:0]  branches;
   logic        flush;
   logic        out_ready;

   logic [3:0]  o_valid, o_taken;
   logic        o_last, o_busy, o_in_ready;
   logic [4:0]  o_left;

   beat_t       sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   te_branch_map_decoder_if #(.N(1), .BRANCH_MAP_LEN(31), .BRANCH_COUNT_LEN(5)) bus1 ();
   te_branch_map_decoder_if #(.N(4), .BRANCH_MAP_LEN(31), .BRANCH_COUNT_LEN(5)) bus4 ();

   te_branch_map_decoder #(.N(1), .BRANCH_MAP_LEN(31), .BRANCH_COUNT_LEN(5)) u_dut1 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus1)
   );

   te_branch_map_decoder #(.N(4), .BRANCH_MAP_LEN(31), .BRANCH_COUNT_LEN(5)) u_dut4 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus4)
   );

   assign bus1.in_valid  = in_valid & (sel == 0);
   assign bus4.in_valid  = in_valid & (sel == 1);
   assign bus1.map       = map;
   assign bus4.map       = map;
   assign bus1.branches  = branches;
   assign bus4.branches  = branches;
   assign bus1.flush     = flush;
   assign bus4.flush     = flush;
   assign bus1.out_ready = out_ready;
   assign bus4.out_ready = out_ready;

   always_comb begin
      o_valid    = {3'b000, bus1.out_valid};
      o_taken    = {3'b000, bus1.out_taken};
      o_last     = bus1.out_last;
      o_busy     = bus1.busy;
      o_in_ready = bus1.in_ready;
      o_left     = bus1.branches_left;
      if (sel == 1) begin
         o_valid    = bus4.out_valid;
         o_taken    = bus4.out_taken;
         o_last     = bus4.out_last;
         o_busy     = bus4.busy;
         o_in_ready = bus4.in_ready;
         o_left     = bus4.branches_left;
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: expand one pair into the beats the decoder should emit.
   function automatic void push_map(input logic [30:0] m, input int br, input int n);
      int    eff, rem, idx, k;
      beat_t b;
      logic [30:0] sh;
      eff = (br > 31) ? 31 : br;
`ifdef TE_BRANCH_MAP_ZERO_IS_FULL_EN
      if (eff == 0) eff = 31;
`endif
      rem = eff;
      idx = 0;
      while (rem > 0) begin
         k = (rem < n) ? rem : n;
         b = '0;
         for (int i = 0; i < k; i++) begin
            sh = m >> (idx + i);
            b.v[i] = 1'b1;
            b.t[i] = ~sh[0];
         end
         b.last = (rem <= n);
         b.left = 5'(rem);
         sb.push_back(b);
         idx += k;
         rem -= k;
      end
   endfunction

   // Beat monitor: compare every presented beat with the scoreboard head; pop on transfer.
   always @(negedge clk) begin
      if (rst_n && (o_valid != 4'b0000)) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got valid=%b taken=%b, expected no beat", o_valid,
                     o_taken);
         end else begin
            if ({o_valid, o_taken, o_last, o_left} !== sb[0]) begin
               n_fail++;
               $display("FAIL beat: got v=%b t=%b last=%b left=%0d, expected v=%b t=%b last=%b left=%0d",
                        o_valid, o_taken, o_last, o_left, sb[0].v, sb[0].t, sb[0].last,
                        sb[0].left);
            end
            if (out_ready) void'(sb.pop_front());
         end
         n_checks++;
         if (o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_during_drain: got %b, expected 0", o_in_ready);
         end
      end
   end

   task automatic send(input logic [30:0] m, input logic [4:0] b);
      @(posedge clk); #1;
      in_valid = 1'b1;
      map      = m;
      branches = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(output int cyc);
      cyc = 0;
      while (sb.size() != 0 && cyc < 400) begin
         @(negedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         n_checks++;
         if ({o_valid, o_taken, o_last, o_busy, o_in_ready, o_left} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: got v=%b t=%b last=%b busy=%b rdy=%b left=%0d, expected 0,0,0,0,1,0",
                     s, o_valid, o_taken, o_last, o_busy, o_in_ready, o_left);
         end
      end
   endtask

   task automatic test_basic_n1();
      int cyc;
      sel = 0;
      out_ready = 1'b1;
      push_map(31'h0000_0005, 3, 1);
      send(31'h0000_0005, 5'd3);
      wait_empty(cyc);
      n_checks++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL basic_n1_beats: got %0d cycles, expected 3", cyc);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({o_in_ready, o_busy, o_valid} !== {1'b1, 1'b0, 4'b0}) begin
         n_fail++;
         $display("FAIL basic_n1_idle: got rdy=%b busy=%b v=%b, expected 1 0 0000", o_in_ready,
                  o_busy, o_valid);
      end
   endtask

   task automatic test_partial_n4();
      int cyc;
      sel = 1;
      out_ready = 1'b1;
      push_map(31'h0, 6, 4);
      send(31'h0, 5'd6);
      wait_empty(cyc);
      n_checks++;
      if (cyc !== 2) begin
         n_fail++;
         $display("FAIL partial_n4_beats: got %0d, expected 2", cyc);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({o_left, o_busy} !== {5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL partial_n4_left: got left=%0d busy=%b, expected 0 0", o_left, o_busy);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      sel = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      push_map(31'h0000_0002, 2, 1);
      send(31'h0000_0002, 5'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if ({o_valid, o_taken, o_left} !== {4'b0001, 4'b0001, 5'd2}) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: got v=%b t=%b left=%0d, expected 0001 0001 2",
                     i, o_valid, o_taken, o_left);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty(cyc);
      n_checks++;
      if (cyc !== 2) begin
         n_fail++;
         $display("FAIL backpressure_release: got %0d beats, expected 2", cyc);
      end
   endtask

   task automatic test_flush();
      int cyc;
      logic [30:0] m;
      sel = 0;
      out_ready = 1'b1;
      m = 31'($urandom);
      push_map(m, 10, 1);
      send(m, 5'd10);
      cyc = 0;
      while (sb.size() > 6 && cyc < 50) begin
         @(negedge clk); #1;
         cyc++;
      end
      n_checks++;
      if (sb.size() !== 6) begin
         n_fail++;
         $display("FAIL flush_setup: got %0d beats left, expected 6", sb.size());
      end
      @(posedge clk); #1;
      flush    = 1'b1;
      in_valid = 1'b1;
      map      = 31'h7fff_ffff;
      branches = 5'd5;
      #1;
      n_checks++;
      if (o_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_in_ready: got %b, expected 0", o_in_ready);
      end
      @(posedge clk); #1;
      sb.delete();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if ({o_valid, o_left, o_busy, o_in_ready} !== {4'b0, 5'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL flush_after: got v=%b left=%0d busy=%b rdy=%b, expected 0 0 0 1", o_valid,
                  o_left, o_busy, o_in_ready);
      end
   endtask

   task automatic test_clamp_zero();
      int cyc;
      logic [30:0] m;
      sel = 0;
      out_ready = 1'b1;
      m = 31'($urandom);
      push_map(m, 31, 1);
      send(m, 5'd31);
      wait_empty(cyc);
      n_checks++;
      if (cyc !== 31) begin
         n_fail++;
         $display("FAIL full_map_beats: got %0d, expected 31", cyc);
      end
      @(negedge clk); #1;
      m = 31'($urandom);
`ifdef TE_BRANCH_MAP_ZERO_IS_FULL_EN
      push_map(m, 0, 1);
      send(m, 5'd0);
      wait_empty(cyc);
      n_checks++;
      if (cyc !== 31) begin
         n_fail++;
         $display("FAIL zero_full_beats: got %0d, expected 31", cyc);
      end
`else
      send(m, 5'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if ({o_valid, o_busy, o_in_ready} !== {4'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_empty[%0d]: got v=%b busy=%b rdy=%b, expected 0 0 1", i, o_valid,
                     o_busy, o_in_ready);
         end
      end
`endif
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [30:0] m;
      sel = 1;
      out_ready = 1'b1;
      m = 31'($urandom);
      push_map(m, 5, 4);
      send(m, 5'd5);
      wait_empty(cyc);
      @(negedge clk); #1;
      n_checks++;
      if ({o_in_ready, o_valid} !== {1'b1, 4'b0}) begin
         n_fail++;
         $display("FAIL b2b_gap: got rdy=%b v=%b, expected 1 0000", o_in_ready, o_valid);
      end
      m = 31'($urandom);
      push_map(m, 9, 4);
      send(m, 5'd9);
      wait_empty(cyc);
      n_checks++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL b2b_second_beats: got %0d, expected 3", cyc);
      end
   endtask

   task automatic test_reset_mid_drain();
      int cyc;
      logic [30:0] m;
      sel = 0;
      out_ready = 1'b1;
      m = 31'($urandom);
      push_map(m, 10, 1);
      send(m, 5'd10);
      cyc = 0;
      while (sb.size() > 7 && cyc < 50) begin
         @(negedge clk); #1;
         cyc++;
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_busy, o_in_ready, o_left} !== {4'b0, 1'b0, 1'b1, 5'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_drain: got v=%b busy=%b rdy=%b left=%0d, expected 0 0 1 0",
                  o_valid, o_busy, o_in_ready, o_left);
      end
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if ({o_valid, o_busy} !== {4'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset[%0d]: got v=%b busy=%b, expected 0 0", i, o_valid, o_busy);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      sel       = 0;
      in_valid  = 1'b0;
      map       = '0;
      branches  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #2;
      test_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      test_basic_n1();
      test_partial_n4();
      test_backpressure();
      test_flush();
      test_clamp_zero();
      test_back_to_back();
      test_reset_mid_drain();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

endmodule
